// File: rtl/uart_led_pkg.sv
// Shared opcodes, state encodings and helpers for the UART LED controller.
package uart_led_pkg;

  localparam logic [3:0] OP_TOGGLE = 4'h0;
  localparam logic [3:0] OP_ON     = 4'h1;
  localparam logic [3:0] OP_OFF    = 4'h2;
  localparam logic [3:0] OP_BLINK  = 4'h3;
  localparam logic [3:0] OP_QUERY  = 4'h4;

  typedef enum logic [1:0] {IDLE, WAIT_ARG, EXEC} state_e;
  typedef enum logic {STEADY, BLINK} mode_e;

  // A blink half-period of 0 ticks is meaningless; run it as 1.
  function automatic logic [7:0] fix_period(input logic [7:0] a);
    return (a == 8'd0) ? 8'd1 : a;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: steady or blinking level with its own period counter.
module led_channel
  import uart_led_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       cmd_vld_i,
  input  logic [3:0] op_i,
  input  logic [7:0] arg_i,
  output logic       led_o
);

  mode_e      mode_q;
  logic       lvl_q;
  logic [7:0] per_q;
  logic [7:0] cnt_q;

  // A command beats a same-cycle tick and always restarts the period count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q <= STEADY;
      lvl_q  <= 1'b0;
      per_q  <= 8'd1;
      cnt_q  <= 8'd0;
    end else if (cmd_vld_i) begin
      cnt_q <= 8'd0;
      case (op_i)
        OP_TOGGLE: begin mode_q <= STEADY; lvl_q <= ~lvl_q; end
        OP_ON:     begin mode_q <= STEADY; lvl_q <= 1'b1;   end
        OP_OFF:    begin mode_q <= STEADY; lvl_q <= 1'b0;   end
        OP_BLINK: begin
          mode_q <= BLINK;
          lvl_q  <= 1'b1;
          per_q  <= fix_period(arg_i);
        end
        default: ;
      endcase
    end else if (tick_i && mode_q == BLINK) begin
      if (cnt_q == per_q - 8'd1) begin
        lvl_q <= ~lvl_q;
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign led_o = lvl_q;

endmodule

// File: rtl/uart_led_ctrl.sv
// UART command decoder: byte edge detect, blink tick divider, command FSM,
// LED channel array and a single-entry status response to the TX path.
module uart_led_ctrl
  import uart_led_pkg::*;
#(
  parameter int LED_NUM     = 6,
  parameter int TICK_DIV    = 5_000_000,
  parameter int ARG_TIMEOUT = 10
) (
  input  logic               clk_50m,
  input  logic               reset,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_done,
  input  logic               uart_tx_busy,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_enable,
  output logic [LED_NUM-1:0] led
);

  localparam int         TW     = $clog2(TICK_DIV);
  localparam int         TOW    = $clog2(ARG_TIMEOUT + 1);
  localparam logic [3:0] CH_LIM = 4'(LED_NUM);

  logic           rx_d_q;
  logic           byte_vld;
  logic [TW-1:0]  tick_q, tick_d;
  logic           tick;
  state_e         state_q;
  logic [3:0]     op_q, ch_q;
  logic [7:0]     arg_q;
  logic [TOW-1:0] to_q;
  logic           pend_q;
  logic           tx_en;
  logic           cmd_vld;
  logic           qry_exec;

  assign byte_vld = uart_rx_done & ~rx_d_q;
  assign tick     = (tick_q == TW'(TICK_DIV - 1));
  assign tick_d   = tick ? '0 : tick_q + TW'(1);

  // Edge register resets high so a level held through reset is not a byte.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      rx_d_q <= 1'b1;
      tick_q <= '0;
    end else begin
      rx_d_q <= uart_rx_done;
      tick_q <= tick_d;
    end
  end

  // Command FSM: collect opcode (and blink argument), then one EXEC cycle.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      ch_q    <= 4'h0;
      arg_q   <= 8'h00;
      to_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_vld) begin
            op_q  <= uart_rx_data[7:4];
            ch_q  <= uart_rx_data[3:0];
            arg_q <= 8'h00;
            to_q  <= '0;
            if (uart_rx_data[7:4] == OP_BLINK && uart_rx_data[3:0] < CH_LIM)
              state_q <= WAIT_ARG;
            else
              state_q <= EXEC;
          end
        end
        WAIT_ARG: begin
          if (byte_vld) begin
            arg_q   <= uart_rx_data;
            state_q <= EXEC;
          end else if (tick) begin
            if (to_q == TOW'(ARG_TIMEOUT - 1)) state_q <= IDLE;
            else                               to_q    <= to_q + TOW'(1);
          end
        end
        EXEC:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_vld  = (state_q == EXEC) && (ch_q < CH_LIM) && (op_q <= OP_BLINK);
  assign qry_exec = (state_q == EXEC) && (op_q == OP_QUERY);

  // One outstanding response; a query landing on the send cycle is absorbed.
  always_ff @(posedge clk_50m) begin
    if (reset)         pend_q <= 1'b0;
    else if (tx_en)    pend_q <= 1'b0;
    else if (qry_exec) pend_q <= 1'b1;
  end

  assign tx_en          = pend_q & ~uart_tx_busy;
  assign uart_tx_enable = tx_en;
  assign uart_tx_data   = tx_en ? 8'(led) : 8'h00;

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    led_channel u_ch (
      .clk_i     (clk_50m),
      .reset_i   (reset),
      .tick_i    (tick),
      .cmd_vld_i (cmd_vld && (ch_q == 4'(i))),
      .op_i      (op_q),
      .arg_i     (arg_q),
      .led_o     (led[i])
    );
  end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Bench for uart_led_ctrl: directed scenarios plus random command traffic,
// all cycles compared against an event-level model of the command rules.
module tb_uart_led_ctrl;

  localparam int LN = 6;
  localparam int TD = 4;
  localparam int AT = 3;

  logic          clk = 1'b0;
  logic          rst, rxd, busy;
  logic [7:0]    rxdat;
  logic [7:0]    txd;
  logic          txe;
  logic [LN-1:0] led;

  always #5 clk = ~clk;

  uart_led_ctrl #(.LED_NUM(LN), .TICK_DIV(TD), .ARG_TIMEOUT(AT)) dut (
    .clk_50m        (clk),
    .reset          (rst),
    .uart_rx_data   (rxdat),
    .uart_rx_done   (rxd),
    .uart_tx_busy   (busy),
    .uart_tx_data   (txd),
    .uart_tx_enable (txe),
    .led            (led)
  );

  int n_vec = 0, n_err = 0;
  int k = 0, r0 = 0;
  bit chk_en = 0, rand_busy = 0;
  int n_txe = 0;
  logic [7:0] last_txd = 8'h00;

  // model: per channel either a steady level or a blink started at edge m_st
  bit m_blk[LN];
  bit m_lvl[LN];
  int m_st[LN];
  int m_per[LN];
  bit pend_m, prev_m, strobe_e;
  bit ex_v;  int ex_at, ex_op, ex_ch, ex_arg;
  bit w_v;   int w_ch, w_dl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // ticks land on edges r0+TD, r0+2TD, ...
  function automatic int ticks_to(input int q);
    return (q - r0) / TD;
  endfunction

  // LED level after clock edge q
  function automatic bit led_at(input int c, input int q);
    int n;
    if (!m_blk[c]) return m_lvl[c];
    n = ticks_to(q) - ticks_to(m_st[c]);
    return ((n / m_per[c]) % 2) == 0;
  endfunction

  function automatic logic [LN-1:0] led_exp();
    logic [LN-1:0] v;
    for (int c = 0; c < LN; c++) v[c] = led_at(c, k);
    return v;
  endfunction

  task automatic model_edge();
    int op, ch;
    bit l;
    if (rst) begin
      r0 = k;
      for (int c = 0; c < LN; c++) begin
        m_blk[c] = 0; m_lvl[c] = 0; m_per[c] = 1; m_st[c] = k;
      end
      pend_m = 0; ex_v = 0; w_v = 0; prev_m = 1;
    end else begin
      if (strobe_e) pend_m = 0;
      else if (ex_v && ex_at == k && ex_op == 4) pend_m = 1;
      if (ex_v && ex_at == k) begin
        if (ex_ch < LN) begin
          case (ex_op)
            0: begin l = led_at(ex_ch, k - 1); m_blk[ex_ch] = 0; m_lvl[ex_ch] = !l; end
            1: begin m_blk[ex_ch] = 0; m_lvl[ex_ch] = 1; end
            2: begin m_blk[ex_ch] = 0; m_lvl[ex_ch] = 0; end
            3: begin m_blk[ex_ch] = 1; m_st[ex_ch] = k; m_per[ex_ch] = (ex_arg == 0) ? 1 : ex_arg; end
            default: ;
          endcase
        end
        ex_v = 0;
      end
      if (rxd && !prev_m) begin
        op = int'(rxdat[7:4]);
        ch = int'(rxdat[3:0]);
        if (w_v && k <= w_dl) begin
          ex_v = 1; ex_at = k + 1; ex_op = 3; ex_ch = w_ch; ex_arg = int'(rxdat);
          w_v = 0;
        end else begin
          w_v = 0;
          if (op == 3 && ch < LN) begin
            w_v = 1; w_ch = ch;
            w_dl = r0 + ((k - r0) / TD + 1) * TD + (AT - 1) * TD;
          end else begin
            ex_v = 1; ex_at = k + 1; ex_op = op; ex_ch = ch; ex_arg = 0;
          end
        end
      end else if (w_v && k >= w_dl) begin
        w_v = 0;
      end
      prev_m = rxd;
    end
  endtask

  // one clock: settle inputs, compare, advance DUT and model by one edge
  task automatic cyc1();
    if (rand_busy) busy = ($urandom_range(0, 2) == 0);
    if (!rxd) rxdat = 8'($urandom);
    #1;
    if (chk_en) begin
      chk("led", 32'(led), 32'(led_exp()));
      chk("txe", 32'(txe), 32'(pend_m & ~busy));
      if (pend_m && !busy) chk("txd", 32'(txd), 32'(led_exp()));
    end
    if (txe === 1'b1) begin n_txe++; last_txd = txd; end
    strobe_e = pend_m & ~busy;
    @(posedge clk);
    k++;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1();
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    rxd = 1'b1; rxdat = b;
    repeat (hold) cyc1();
    rxd = 1'b0;
    repeat (gap) cyc1();
  endtask

  int  tog;
  bit  pl;
  logic [7:0] b;

  initial begin
    rst = 1'b1; rxd = 1'b0; busy = 1'b0; rxdat = 8'h00;
    @(negedge clk);
    cyc1(); cyc1();
    chk_en = 1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_txe", 32'(txe), 32'h0);
    chk("rst_txd", 32'(txd), 32'h0);
    rst = 1'b0;
    idle(3);

    // legacy toggles, with the two-clock latency checked explicitly
    rxd = 1'b1; rxdat = 8'h00;
    cyc1(); chk("lat1", 32'(led), 32'h0);
    cyc1(); chk("lat2", 32'(led), 32'h1);
    rxd = 1'b0; idle(4);
    send(8'h05, 1, 5);
    send(8'h00, 2, 5);
    chk("legacy", 32'(led), 32'h20);

    // set / clear / out-of-range channel
    send(8'h12, 1, 5); chk("set2", 32'(led), 32'h24);
    send(8'h22, 1, 5); chk("clr2", 32'(led), 32'h20);
    send(8'h17, 1, 5); chk("badch", 32'(led), 32'h20);
    send(8'h10, 1, 5); chk("after_bad", 32'(led), 32'h21);

    // blink period 3 ticks: a toggle every 12 clocks
    send(8'h31, 1, 2);
    rxd = 1'b1; rxdat = 8'h03; cyc1(); rxd = 1'b0; cyc1();
    chk("blink_on", 32'(led[1]), 32'h1);
    tog = 0; pl = led[1];
    repeat (48) begin cyc1(); if (led[1] != pl) tog++; pl = led[1]; end
    chk("blink3_tog", 32'(tog), 32'd4);
    idle(5);
    send(8'h01, 1, 4);
    pl = led[1];
    idle(30);
    chk("blink_stop", 32'(led[1]), 32'(pl));
    // period 0 runs as 1 tick
    send(8'h31, 1, 2);
    rxd = 1'b1; rxdat = 8'h00; cyc1(); rxd = 1'b0; cyc1();
    tog = 0; pl = led[1];
    repeat (16) begin cyc1(); if (led[1] != pl) tog++; pl = led[1]; end
    chk("blink1_tog", 32'(tog), 32'd4);

    // argument timeout drops the blink; next byte is a fresh command
    send(8'h20, 1, 5);
    send(8'h30, 1, 20);
    send(8'h10, 1, 6);
    chk("tmo_set0", 32'(led[0]), 32'h1);
    idle(70);
    chk("tmo_steady", 32'(led[0]), 32'h1);

    // busy-held queries collapse into one response
    for (int c = 0; c < LN; c++) send(8'h20 | 8'(c), 1, 3);
    send(8'h10, 1, 3);
    send(8'h15, 1, 3);
    chk("q_led", 32'(led), 32'h21);
    busy = 1'b1; n_txe = 0;
    send(8'h40, 1, 6);
    send(8'h40, 1, 6);
    chk("q_busy", 32'(n_txe), 32'd0);
    busy = 1'b0;
    idle(10);
    chk("q_cnt", 32'(n_txe), 32'd1);
    chk("q_data", 32'(last_txd), 32'h21);

    // reset in WAIT_ARG with a pending query
    busy = 1'b1;
    send(8'h40, 1, 4);
    send(8'h31, 1, 2);
    rst = 1'b1; rxd = 1'b1; rxdat = 8'h03;
    cyc1(); cyc1();
    rst = 1'b0; busy = 1'b0;
    cyc1();
    chk("r2_led", 32'(led), 32'h0);
    chk("r2_txe", 32'(txe), 32'h0);
    chk("r2_txd", 32'(txd), 32'h0);
    n_txe = 0;
    idle(2); rxd = 1'b0; idle(10);
    chk("r2_nopend", 32'(n_txe), 32'd0);
    chk("r2_heldlvl", 32'(led), 32'h0);
    send(8'h05, 1, 6);
    chk("r2_tog5", 32'(led), 32'h20);

    // random command traffic with random TX back-pressure
    rand_busy = 1;
    repeat (150) begin
      int sel, ch;
      sel = $urandom_range(0, 9);
      ch  = $urandom_range(0, 7);
      case (sel)
        0, 1:    b = {4'h0, 4'(ch)};
        2:       b = {4'h1, 4'(ch)};
        3:       b = {4'h2, 4'(ch)};
        4, 5:    b = {4'h3, 4'(ch)};
        6, 7:    b = {4'h4, 4'(ch)};
        default: b = 8'($urandom);
      endcase
      if (sel == 4 || sel == 5) begin
        send(b, $urandom_range(1, 3), $urandom_range(1, 3));
        if (ch < LN) send(8'($urandom_range(0, 3)), $urandom_range(1, 3), $urandom_range(2, 20));
      end else begin
        send(b, $urandom_range(1, 3), $urandom_range(2, 20));
      end
    end
    rand_busy = 0; busy = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
